// File: rtl/instr_sequencer_pkg.sv
// Shared types and encodings for the instruction sequencer: FSM states,
// instruction classes and the opcode/funct values the classifier recognises.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU_WB,
        CLS_ALU_NOWB,
        CLS_JUMP,
        CLS_BRANCH,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } iclass_t;

    // R-type funct field: 000..FUNCT_ALU_LAST write back, then CMP and NOP
    localparam logic [2:0] FUNCT_ALU_LAST = 3'b101;
    localparam logic [2:0] FUNCT_CMP      = 3'b110;
    localparam logic [2:0] FUNCT_NOP      = 3'b111;

    localparam logic [3:0] OP_LDI  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_JMP  = 4'b0010;
    localparam logic [3:0] OP_BZ   = 4'b0011;
    localparam logic [3:0] OP_HALT = 4'b1111;

endpackage

// File: rtl/instr_sequencer_class.sv
// Combinational instruction classifier: maps a 16-bit instruction word to
// the class that steers the sequencer FSM.
module instr_class
    import seq_pkg::*;
(
    input  logic [15:0] instr,
    output logic [2:0]  cls
);

    iclass_t cls_int;
    logic    unused_bits;

    // Register fields and immediate bits do not affect sequencing
    assign unused_bits = ^{instr[10:9], instr[5:0]};

    always_comb begin
        cls_int = CLS_ILLEGAL;
        if (!instr[15]) begin
            if (instr[8:6] <= FUNCT_ALU_LAST) begin
                cls_int = CLS_ALU_WB;
            end else if (instr[8:6] == FUNCT_CMP) begin
                cls_int = CLS_ALU_NOWB;
            end else begin
                cls_int = CLS_NOP;
            end
        end else begin
            case (instr[14:11])
                OP_LDI, OP_ADDI: cls_int = CLS_ALU_WB;
                OP_JMP:          cls_int = CLS_JUMP;
                OP_BZ:           cls_int = CLS_BRANCH;
                OP_HALT:         cls_int = CLS_HALT;
                default:         cls_int = CLS_ILLEGAL;
            endcase
        end
    end

    assign cls = cls_int;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer: owns the PC, the
// instruction register and the imem/ALU handshakes.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     ir,
    output logic            exe_valid,
    input  logic            exe_ready,
    input  logic            zero_flag,
    output logic            rf_we,
    output logic [PC_W-1:0] pc,
    output logic            illegal,
    output logic            halted
);

    state_t     state_reg;
    iclass_t    cls_reg;
    logic       bz_taken_reg;
    logic [2:0] fetch_cls_raw;
    iclass_t    fetch_cls;

    // Classify the word as it arrives so the class is registered next to ir
    // and illegal can be a registered pulse during DECODE.
    instr_class u_class (
        .instr (imem_rdata),
        .cls   (fetch_cls_raw)
    );

    assign fetch_cls = iclass_t'(fetch_cls_raw);
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cls_reg      <= CLS_NOP;
            bz_taken_reg <= 1'b0;
            pc           <= RESET_PC;
            ir           <= 16'h0000;
            imem_req     <= 1'b0;
            exe_valid    <= 1'b0;
            rf_we        <= 1'b0;
            illegal      <= 1'b0;
            halted       <= 1'b0;
        end else begin
            rf_we   <= 1'b0;
            illegal <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_FETCH;
                        imem_req  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (imem_req && imem_ack) begin
                        ir        <= imem_rdata;
                        cls_reg   <= fetch_cls;
                        illegal   <= (fetch_cls == CLS_ILLEGAL);
                        imem_req  <= 1'b0;
                        state_reg <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    bz_taken_reg <= zero_flag;
                    case (cls_reg)
                        CLS_ALU_WB, CLS_ALU_NOWB: begin
                            exe_valid <= 1'b1;
                            state_reg <= ST_EXECUTE;
                        end
                        CLS_HALT: begin
                            halted    <= 1'b1;
                            state_reg <= ST_HALT;
                        end
                        default: state_reg <= ST_WRITEBACK;
                    endcase
                end
                ST_EXECUTE: begin
                    if (exe_valid && exe_ready) begin
                        exe_valid <= 1'b0;
                        rf_we     <= (cls_reg == CLS_ALU_WB);
                        state_reg <= ST_WRITEBACK;
                    end
                end
                ST_WRITEBACK: begin
                    // Jump target is the low PC_W bits of the 8-bit immediate
                    if (cls_reg == CLS_JUMP || (cls_reg == CLS_BRANCH && bz_taken_reg)) begin
                        pc <= ir[PC_W-1:0];
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                    imem_req  <= 1'b1;
                    state_reg <= ST_FETCH;
                end
                ST_HALT: begin
                    state_reg <= ST_HALT;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    imem_req  <= 1'b0;
                    exe_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed vector table, reset and
// halt sequences, then randomized instructions against an ISA-level model.
module tb_instr_sequencer;

    localparam int PC_W = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [15:0]     imem_rdata;
    logic [15:0]     ir;
    logic            exe_valid;
    logic            exe_ready;
    logic            zero_flag;
    logic            rf_we;
    logic [PC_W-1:0] pc;
    logic            illegal;
    logic            halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_sequencer #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .exe_valid  (exe_valid),
        .exe_ready  (exe_ready),
        .zero_flag  (zero_flag),
        .rf_we      (rf_we),
        .pc         (pc),
        .illegal    (illegal),
        .halted     (halted)
    );

    localparam int K_ALU_WB = 0, K_ALU_NOWB = 1, K_JMP = 2, K_BZ = 3,
                   K_NOP = 4, K_HALT = 5, K_ILL = 6;

    typedef struct {
        logic [15:0] instr;
        int          ack_wait;
        int          rdy_wait;
        bit          zf;
        logic [7:0]  exp_pc;
        int          exp_exe;
        int          exp_rfwe;
        int          exp_ill;
        int          exp_cycles;
        int          exp_halt;
    } vec_t;

    typedef struct {
        logic        req0;
        logic [7:0]  addr0;
        logic [15:0] ir_val;
        logic        ill_dec;
        int          ill_cnt;
        int          exe;
        int          rfwe;
        int          cycles;
        logic [7:0]  next_pc;
        logic        next_req;
        logic        halted_v;
        bit          timeout;
    } obs_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ISA-level reference: class of a word, straight from the format table
    function automatic int kind_of(input logic [15:0] i);
        logic [2:0] f;
        logic [3:0] op;
        f  = i[8:6];
        op = i[14:11];
        if (!i[15]) begin
            if (f == 3'd7) return K_NOP;
            if (f == 3'd6) return K_ALU_NOWB;
            return K_ALU_WB;
        end
        case (op)
            4'd0, 4'd1: return K_ALU_WB;
            4'd2:       return K_JMP;
            4'd3:       return K_BZ;
            4'd15:      return K_HALT;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic vec_t model(input logic [15:0] instr, input int ack, input int rdy,
                                   input bit zf, input logic [7:0] cur_pc);
        vec_t v;
        int   k;
        bit   alu;
        k   = kind_of(instr);
        alu = (k == K_ALU_WB) || (k == K_ALU_NOWB);
        v.instr      = instr;
        v.ack_wait   = ack;
        v.rdy_wait   = rdy;
        v.zf         = zf;
        v.exp_exe    = alu ? rdy + 1 : 0;
        v.exp_rfwe   = (k == K_ALU_WB) ? 1 : 0;
        v.exp_ill    = (k == K_ILL) ? 1 : 0;
        v.exp_halt   = (k == K_HALT) ? 1 : 0;
        v.exp_cycles = (k == K_HALT) ? ack + 2 : ack + 3 + v.exp_exe;
        if (k == K_JMP || (k == K_BZ && zf)) v.exp_pc = instr[7:0];
        else if (k == K_HALT)                v.exp_pc = cur_pc;
        else                                 v.exp_pc = cur_pc + 8'd1;
        return v;
    endfunction

    // Entered at a falling edge in the first FETCH cycle; returns at the
    // falling edge of the next FETCH cycle (or once halted is seen).
    task automatic run_instr(input vec_t v, output obs_t o);
        o = '{default: 0};
        o.req0  = imem_req;
        o.addr0 = imem_addr;
        imem_ack = 1'b0;
        for (int w = 0; w < v.ack_wait; w++) begin
            imem_rdata = 16'($urandom);
            @(negedge clk);
            o.cycles++;
        end
        imem_ack   = 1'b1;
        imem_rdata = v.instr;
        zero_flag  = ~v.zf;
        @(negedge clk);
        o.cycles++;
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        o.ir_val   = ir;
        o.ill_dec  = illegal;
        zero_flag  = v.zf;
        o.timeout  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (illegal) o.ill_cnt++;
            if (rf_we) o.rfwe++;
            if (exe_valid) begin
                o.exe++;
                exe_ready = (o.exe == v.rdy_wait + 1);
            end else begin
                exe_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            o.cycles++;
            zero_flag = ~v.zf;
            if (imem_req || halted) begin
                o.timeout = 1'b0;
                break;
            end
        end
        exe_ready  = 1'b0;
        o.next_req = imem_req;
        o.next_pc  = imem_addr;
        o.halted_v = halted;
    endtask

    task automatic do_instr(input vec_t v, inout logic [7:0] mpc);
        obs_t o;
        run_instr(v, o);
        $display("instr %04h at %02h -> pc %02h ack_wait %0d rdy_wait %0d zf %0d cycles %0d",
                 v.instr, o.addr0, o.next_pc, v.ack_wait, v.rdy_wait, v.zf, o.cycles);
        check("req_at_fetch", o.req0, 1);
        check("fetch_addr", o.addr0, mpc);
        check("ir_loaded", o.ir_val, v.instr);
        check("illegal_in_decode", o.ill_dec, v.exp_ill);
        check("illegal_pulses", o.ill_cnt, v.exp_ill);
        check("exe_valid_cycles", o.exe, v.exp_exe);
        check("rf_we_pulses", o.rfwe, v.exp_rfwe);
        check("timeout", o.timeout, 0);
        check("cycles", o.cycles, v.exp_cycles);
        check("next_pc", o.next_pc, v.exp_pc);
        check("next_req", o.next_req, (v.exp_halt == 0));
        check("halted", o.halted_v, v.exp_halt);
        mpc = v.exp_pc;
    endtask

    task automatic halt_freeze(input logic [7:0] exp_pc);
        int bad_req = 0, bad_halt = 0, bad_pc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (imem_req !== 1'b0) bad_req++;
            if (halted !== 1'b1) bad_halt++;
            if (pc !== exp_pc) bad_pc++;
        end
        check("halt_req_low", bad_req, 0);
        check("halt_stays", bad_halt, 0);
        check("halt_pc_frozen", bad_pc, 0);
    endtask

    initial begin
        logic [7:0]  mpc;
        logic [15:0] w;
        vec_t        v;

        tbl[0] = '{16'h000A, 2, 2, 1'b0, 8'h01, 3, 1, 0, 8, 0}; // ADD
        tbl[1] = '{16'h90FF, 0, 0, 1'b0, 8'hFF, 0, 0, 0, 3, 0}; // JMP 0xFF
        tbl[2] = '{16'h01C0, 1, 0, 1'b1, 8'h00, 0, 0, 0, 4, 0}; // NOP, pc wraps
        tbl[3] = '{16'h9810, 0, 0, 1'b1, 8'h10, 0, 0, 0, 3, 0}; // BZ taken
        tbl[4] = '{16'h9810, 0, 0, 1'b0, 8'h11, 0, 0, 0, 3, 0}; // BZ not taken
        tbl[5] = '{16'hA800, 0, 0, 1'b0, 8'h12, 0, 0, 1, 3, 0}; // illegal
        tbl[6] = '{16'h0180, 0, 1, 1'b0, 8'h13, 2, 0, 0, 5, 0}; // CMP
        tbl[7] = '{16'h8005, 3, 0, 1'b0, 8'h14, 1, 1, 0, 7, 0}; // LDI
        tbl[8] = '{16'h88FF, 0, 0, 1'b1, 8'h15, 1, 1, 0, 4, 0}; // ADDI
        tbl[9] = '{16'hF800, 1, 0, 1'b0, 8'h15, 0, 0, 0, 3, 1}; // HALT

        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0;
        exe_ready = 1'b0; zero_flag = 1'b0;
        #12;
        check("rst_pc", pc, 8'h00);
        check("rst_ir", ir, 16'h0000);
        check("rst_imem_req", imem_req, 0);
        check("rst_exe_valid", exe_valid, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_illegal", illegal, 0);
        check("rst_halted", halted, 0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_req", imem_req, 0);
        check("idle_pc", pc, 8'h00);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_req", imem_req, 1);
        check("start_addr", imem_addr, 8'h00);

        mpc = 8'h00;
        for (int i = 0; i < 10; i++) do_instr(tbl[i], mpc);
        halt_freeze(8'h15);

        // Reset abandoning an ALU handshake after moving pc away from reset
        rst_n = 1'b0;
        #1;
        check("rst_clears_halted", halted, 0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mpc = 8'h00;
        do_instr('{16'h9040, 0, 0, 1'b0, 8'h40, 0, 0, 0, 3, 0}, mpc);
        imem_ack = 1'b1;
        imem_rdata = 16'h000A;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        check("pre_reset_exe_valid", exe_valid, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_exe_valid", exe_valid, 0);
        check("midop_imem_req", imem_req, 0);
        check("midop_pc", pc, 8'h00);
        check("midop_ir", ir, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("after_reset_idle", imem_req, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_req", imem_req, 1);

        mpc = 8'h00;
        for (int i = 0; i < 150; i++) begin
            do begin
                w = 16'($urandom);
            end while (kind_of(w) == K_HALT);
            v = model(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), mpc);
            do_instr(v, mpc);
        end
        v = model(16'hFFFF, 0, 0, 1'b0, mpc);
        do_instr(v, mpc);
        halt_freeze(mpc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control sequencer for the mini-processor core. Fetches 16-bit instructions from instruction memory over a req/ack handshake and holds them in an instruction register that feeds the existing instruction decoder. Classifies each instruction, sequences the ALU through a valid/ready handshake, and updates the program counter (increment, jump, branch-on-zero). It also generates register-file write strobes, illegal-opcode flags and halt status.

## Interface
- PC_W, 8, program-counter / instruction-memory address width (matches 8-bit immediate)
- RESET_PC, 0, PC value loaded at reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE and begin fetching; sampled only in IDLE
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  PC_W  fetch address (= pc), stable while imem_req=1
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  16  fetched instruction
- ir  out  16  instruction register, drives the decoder
- exe_valid  out  1  ALU operation request
- exe_ready  in  1  ALU done; handshake completes when exe_valid && exe_ready
- zero_flag  in  1  ALU zero flag from the last completed operation
- rf_we  out  1  register-file write strobe, one cycle
- pc  out  PC_W  current program counter
- illegal  out  1  one-cycle pulse when an undefined opcode is decoded
- halted  out  1  high in HALT state

## Operation
- **Formats**
  - ir[15]=0: R-type. funct=ir[8:6].
    - 000–101: ALU operation with writeback.
    - 110: CMP, ALU operation without writeback.
    - 111: NOP.
  - ir[15]=1: I-type. op=ir[14:11], imm=ir[7:0].
    - 0000 LDI and 0001 ADDI: ALU operation with writeback.
    - 0010 JMP.
    - 0011 BZ.
    - 1111 HALT.
    - Any other op is illegal and executes as a NOP.
- **States:** IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- **Transitions**
  - IDLE → FETCH when start=1.
  - FETCH: imem_req=1. On imem_ack, ir ← imem_rdata, then → DECODE.
  - DECODE: one cycle.
    - ALU-class instruction → EXECUTE.
    - JMP, BZ, NOP, illegal → WRITEBACK.
    - HALT → HALT.
    - illegal pulses in this cycle.
    - BZ samples zero_flag in this cycle.
  - EXECUTE: exe_valid=1 until the handshake completes, then → WRITEBACK.
  - WRITEBACK: one cycle, then → FETCH.
    - rf_we=1 for writeback-class instructions only.
    - PC update in this cycle:
      - JMP: pc ← imm[PC_W-1:0].
      - BZ taken: pc ← imm[PC_W-1:0].
      - Otherwise: pc ← pc+1, modulo 2^PC_W (0xFF → 0x00 wraps silently).
  - HALT: absorbing; only rst_n exits. pc is frozen.
- ir holds its value outside FETCH; the decoder inputs never change mid-instruction.
- imem_ack is ignored when imem_req=0. exe_ready is ignored when exe_valid=0.

## Timing
- **Reset values:** state=IDLE, pc=RESET_PC, ir=16'h0000, imem_req=0, exe_valid=0, rf_we=0, illegal=0, halted=0.
- Assertion of rst_n takes effect immediately (asynchronous), including mid-fetch or mid-execute. Outstanding handshakes are abandoned. imem_req and exe_valid drop with reset.
- **Zero-wait cycles per instruction** (ack/ready in the first cycle asserted): FETCH 1 + DECODE 1 + WRITEBACK 1 = 3 cycles for jump/branch/NOP. Add 1 + ALU wait cycles for ALU-class instructions.
- imem_req rises on the cycle after the IDLE→FETCH or WRITEBACK→FETCH edge. imem_addr reflects the updated pc in that same cycle.
- If imem_ack arrives in the first cycle of imem_req, ir updates at the end of that cycle.
- All outputs are registered or decoded directly from state; there are no combinational paths from inputs to outputs.
- halted rises the cycle after DECODE of HALT.

## Structure
- **Package `seq_pkg`:**
  - state enum.
  - funct constants (ALU range, CMP, NOP).
  - I-type op constants (LDI, ADDI, JMP, BZ, HALT).
  - instruction-class enum: ALU_WB, ALU_NOWB, JUMP, BRANCH, NOP, HALT, ILLEGAL.
- **Sub-module `instr_class`:** purely combinational; ir in, class out. The FSM and pc/ir registers live in the top module.

## Test plan
- **Reset and idle:** reset, start=0 for 5 cycles → pc=0, imem_req=0, all outputs at reset values. Pulse start → imem_req=1 and imem_addr=0 on the next cycle.
- **ALU with writeback:** imem_rdata=16'h000A (R-type ADD), ack after 2 wait cycles, exe_ready after 3 cycles.
  - ir=16'h000A after ack.
  - exe_valid is held high for 3 cycles.
  - rf_we pulses exactly once.
  - pc goes 0→1.
- **Jump and wrap:**
  - JMP: 16'h90FF (op 0010, imm 0xFF) → pc=0xFF, no exe_valid, no rf_we.
  - Next instruction NOP at 0xFF → pc wraps to 0x00.
- **Branch on zero:** BZ 16'h9810 (op 0011, imm 0x10).
  - zero_flag=1 in DECODE → pc=0x10.
  - Repeat with zero_flag=0 → pc=old pc+1.
- **Illegal and halt:**
  - op 0101 (16'hA800) → illegal pulses 1 cycle, pc+1.
  - Then HALT (16'hF800) → halted=1, imem_req stays 0, pc frozen for 20 cycles.
- **Reset mid-operation:** assert rst_n=0 while exe_valid=1 → exe_valid and imem_req drop in the same cycle, state=IDLE, pc=RESET_PC.
